// File: rtl/led_seq_arbiter.sv
// Two-requester round-robin owner of a 3-to-8 LED decoder display.
// With no owner the display steps through an auto sequence paced by the prescaler tick.
module led_seq_arbiter #(
   parameter int unsigned TICK_DIV   = 62500000,
   parameter int unsigned HOLD_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [2:0] code0,
   input  logic [2:0] code1,
   output logic [1:0] grant,
   output logic [2:0] sel_code,
   output logic       tick,
   output logic       done
);

   localparam logic [27:0] TICK_LAST = 28'(TICK_DIV - 1);
   localparam logic [3:0]  HOLD_LAST = 4'(HOLD_TICKS - 1);

   typedef enum logic {
      AUTO = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   logic [27:0] presc;
   logic [2:0]  auto_cnt;
   logic [3:0]  hold_cnt;
   logic        last_srv;
   logic        owner;
   logic        winner;
   logic        release_now;

   // Round-robin choice: a lone request wins outright, a tie goes to the
   // requester that was not served last.
   function automatic logic rr_pick(input logic [1:0] r, input logic last);
      case (r)
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~last;
      endcase
   endfunction

   function automatic logic [2:0] code_of(input logic idx, input logic [2:0] c0,
                                          input logic [2:0] c1);
      return idx ? c1 : c0;
   endfunction

   assign tick        = (presc == TICK_LAST);
   assign owner       = grant[1];
   assign winner      = rr_pick(req, last_srv);
   assign release_now = !req[owner] || (tick && (hold_cnt == HOLD_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 28'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= AUTO;
         auto_cnt <= '0;
         hold_cnt <= '0;
         last_srv <= 1'b1;
         grant    <= 2'b00;
         sel_code <= 3'b000;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            AUTO: begin
               if (tick) begin
                  auto_cnt <= auto_cnt + 3'd1;
               end
               if (req != 2'b00) begin
                  state    <= HOLD;
                  grant    <= winner ? 2'b10 : 2'b01;
                  sel_code <= code_of(winner, code0, code1);
                  hold_cnt <= '0;
               end else begin
                  sel_code <= tick ? auto_cnt + 3'd1 : auto_cnt;
               end
            end
            HOLD: begin
               // Auto counter stays frozen here; the display shows it again on release.
               if (release_now) begin
                  state    <= AUTO;
                  grant    <= 2'b00;
                  sel_code <= auto_cnt;
                  last_srv <= owner;
                  hold_cnt <= '0;
                  done     <= 1'b1;
               end else if (tick) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end
            default: begin
               state <= AUTO;
               grant <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_seq_arbiter.sv
// Scoreboard bench for led_seq_arbiter with TICK_DIV=4, HOLD_TICKS=2.
// Stimulus queues per-cycle expectations; a negedge monitor pops and compares them.
module tb_led_seq_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [2:0] code0 = 3'd0;
   logic [2:0] code1 = 3'd0;
   logic [1:0] grant;
   logic [2:0] sel_code;
   logic       tick;
   logic       done;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         c;
      logic [1:0] g;
      logic [2:0] s;
      logic       t;
      logic       d;
      string      nm;
   } exp_t;

   exp_t sb[$];

   led_seq_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
      .clk(clk), .rst(rst), .req(req), .code0(code0), .code1(code1),
      .grant(grant), .sel_code(sel_code), .tick(tick), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation due in the current cycle.
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (grant == 2'b11) begin
         errors++;
         $display("FAIL onehot cyc=%0d: grant=%b, must never be 11", cyc, grant);
      end
      while (sb.size() > 0 && sb[0].c <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (grant !== e.g || sel_code !== e.s || tick !== e.t || done !== e.d) begin
            errors++;
            $display("FAIL %s cyc=%0d: got grant=%b sel=%0d tick=%b done=%b, want grant=%b sel=%0d tick=%b done=%b",
                     e.nm, cyc, grant, sel_code, tick, done, e.g, e.s, e.t, e.d);
         end
      end
   end

   task automatic push_exp(input int c, input logic [1:0] g, input logic [2:0] s,
                           input logic t, input logic d, input string nm);
      exp_t e;
      e.c = c; e.g = g; e.s = s; e.t = t; e.d = d; e.nm = nm;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   // Leaves the bench 1 time unit after the last reset edge; base = that edge's cycle.
   task automatic do_reset(output int base);
      rst = 1'b1;
      req = 2'b00;
      step(2);
      rst = 1'b0;
      base = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int r;

      // Free-running auto sequence with no requests.
      do_reset(r);
      push_exp(r, 2'b00, 3'd0, 1'b0, 1'b0, "reset_state");
      for (int k = 1; k <= 40; k++)
         push_exp(r + k, 2'b00, 3'((k / 4) % 8), (k % 4) == 3, 1'b0, "auto_seq");
      wait_until(r + 41);

      // Tie from reset: requester 0 first, then 1 after one AUTO cycle, then 0 again.
      do_reset(r);
      code0 = 3'd5; code1 = 3'd3; req = 2'b11;
      for (int k = 1; k <= 7; k++)
         push_exp(r + k, 2'b01, 3'd5, (k % 4) == 3, 1'b0, "tie_own0");
      push_exp(r + 8, 2'b00, 3'd0, 1'b0, 1'b1, "tie_rel0");
      for (int k = 9; k <= 15; k++)
         push_exp(r + k, 2'b10, 3'd3, (k % 4) == 3, 1'b0, "tie_own1");
      push_exp(r + 16, 2'b00, 3'd0, 1'b0, 1'b1, "tie_rel1");
      push_exp(r + 17, 2'b01, 3'd5, 1'b0, 1'b0, "tie_regrant0");
      push_exp(r + 18, 2'b00, 3'd0, 1'b0, 1'b1, "tie_drop_rel");
      push_exp(r + 19, 2'b00, 3'd0, 1'b1, 1'b0, "tie_after_tick");
      push_exp(r + 20, 2'b00, 3'd1, 1'b0, 1'b0, "tie_auto_resume");
      wait_until(r + 17);
      req = 2'b00;
      wait_until(r + 21);

      // Early release restores the frozen auto value.
      do_reset(r);
      push_exp(r + 9,  2'b00, 3'd2, 1'b0, 1'b0, "early_pre");
      push_exp(r + 10, 2'b01, 3'd6, 1'b0, 1'b0, "early_grant");
      push_exp(r + 11, 2'b01, 3'd6, 1'b1, 1'b0, "early_hold_tick");
      push_exp(r + 12, 2'b01, 3'd6, 1'b0, 1'b0, "early_hold");
      push_exp(r + 13, 2'b00, 3'd2, 1'b0, 1'b1, "early_release");
      push_exp(r + 14, 2'b00, 3'd2, 1'b0, 1'b0, "early_done_clear");
      push_exp(r + 15, 2'b00, 3'd2, 1'b1, 1'b0, "early_tick");
      push_exp(r + 16, 2'b00, 3'd3, 1'b0, 1'b0, "early_auto_step");
      wait_until(r + 9);
      code0 = 3'd6; req = 2'b01;
      wait_until(r + 12);
      req = 2'b00;
      wait_until(r + 17);

      // Latched code holds through a code change; non-owner request is ignored.
      do_reset(r);
      code0 = 3'd5; code1 = 3'd7; req = 2'b01;
      push_exp(r + 1, 2'b01, 3'd5, 1'b0, 1'b0, "latch_grant");
      push_exp(r + 2, 2'b01, 3'd5, 1'b0, 1'b0, "latch_code_chg");
      for (int k = 3; k <= 7; k++)
         push_exp(r + k, 2'b01, 3'd5, (k % 4) == 3, 1'b0, "latch_no_preempt");
      push_exp(r + 8,  2'b00, 3'd0, 1'b0, 1'b1, "latch_release");
      push_exp(r + 9,  2'b10, 3'd7, 1'b0, 1'b0, "latch_next_owner1");
      push_exp(r + 10, 2'b00, 3'd0, 1'b0, 1'b1, "latch_drop1");
      push_exp(r + 11, 2'b00, 3'd0, 1'b1, 1'b0, "latch_idle");
      wait_until(r + 2);
      code0 = 3'd2;
      wait_until(r + 3);
      req = 2'b11;
      wait_until(r + 9);
      req = 2'b00;
      wait_until(r + 12);

      // Reset during HOLD: no done pulse, pointer back to 1, prescaler restarts.
      do_reset(r);
      code0 = 3'd4; code1 = 3'd6; req = 2'b01;
      push_exp(r + 1, 2'b01, 3'd4, 1'b0, 1'b0, "rst_hold_grant");
      push_exp(r + 2, 2'b01, 3'd4, 1'b0, 1'b0, "rst_hold");
      push_exp(r + 3, 2'b00, 3'd0, 1'b0, 1'b0, "rst_abandon");
      push_exp(r + 4, 2'b00, 3'd0, 1'b0, 1'b0, "rst_no_done");
      push_exp(r + 5, 2'b00, 3'd0, 1'b0, 1'b0, "rst_presc2");
      push_exp(r + 6, 2'b00, 3'd0, 1'b1, 1'b0, "rst_first_tick");
      push_exp(r + 7, 2'b00, 3'd1, 1'b0, 1'b0, "rst_auto1");
      push_exp(r + 8, 2'b01, 3'd4, 1'b0, 1'b0, "rst_tie_ptr");
      push_exp(r + 9, 2'b00, 3'd1, 1'b0, 1'b1, "rst_tie_rel");
      push_exp(r + 10, 2'b00, 3'd1, 1'b1, 1'b0, "rst_tail");
      wait_until(r + 2);
      rst = 1'b1; req = 2'b00;
      step(1);
      rst = 1'b0;
      wait_until(r + 7);
      req = 2'b11;
      wait_until(r + 8);
      req = 2'b00;
      wait_until(r + 11);

      step(1);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_seq_arbiter.md
LED_SEQ_ARBITER -- requirements
Module: led_seq_arbiter

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 62500000, clock cycles per display tick (legal range 2..2^28).
REQ-002 The module SHALL have parameter HOLD_TICKS, default 4, ticks a granted requester keeps the display (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port req, input, 2 bits: display requests, req[i] from requester i, level-sensitive.
REQ-006 The module SHALL have port code0, input, 3 bits: display code offered by requester 0.
REQ-007 The module SHALL have port code1, input, 3 bits: display code offered by requester 1.
REQ-008 The module SHALL have port grant, output, 2 bits: registered one-hot grant to the current owner, 00 when no owner.
REQ-009 The module SHALL have port sel_code, output, 3 bits: registered code driven to the downstream 3-to-8 decoder inputs (a=bit2, b=bit1, c=bit0).
REQ-010 The module SHALL have port tick, output, 1 bit: one-cycle pulse at each prescaler terminal count.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse in the cycle a grant is released.

Function
REQ-012 The prescaler SHALL be a 28-bit counter that counts 0..TICK_DIV-1 and wraps to 0; tick SHALL be 1 exactly while the counter equals TICK_DIV-1.
REQ-013 The prescaler SHALL run in every state, independent of arbitration.
REQ-014 The FSM SHALL have two states: AUTO (no owner) and HOLD (one requester owns the display).
REQ-015 In AUTO, a 3-bit auto counter SHALL increment on each tick, wrapping 7->0, and sel_code SHALL equal the auto counter.
REQ-016 In AUTO with req != 00 at a clock edge, the FSM SHALL move to HOLD; grant, sel_code (winner's code, latched at that edge) and the hold counter (cleared to 0) SHALL all update at the same edge (one-cycle request-to-grant latency).
REQ-017 Arbitration SHALL be round-robin: for a single request that requester wins; for req=11 the requester not served last wins; after reset the last-served pointer SHALL be 1, so requester 0 wins the first tie.
REQ-018 In HOLD, sel_code SHALL stay at the latched code even if code0/code1 change; the auto counter SHALL freeze.
REQ-019 In HOLD, the 4-bit hold counter SHALL increment on each tick; on a tick with hold counter = HOLD_TICKS-1 the grant SHALL be released.
REQ-020 In HOLD, if the owner's req bit is 0 at a clock edge, the grant SHALL be released at that edge (early release), regardless of tick.
REQ-021 On release: grant SHALL become 00, the FSM SHALL return to AUTO, sel_code SHALL return to the frozen auto counter value, the last-served pointer SHALL record the released owner, and done SHALL pulse for that cycle.
REQ-022 A request pending at release SHALL not be granted in the release cycle; it SHALL be evaluated in AUTO at the next edge (minimum one AUTO cycle between grants).
REQ-023 A non-owner request during HOLD SHALL be ignored (no preemption).
REQ-024 grant SHALL never be 11.

Reset
REQ-025 While rst=1 at a clock edge: prescaler=0, auto counter=0, hold counter=0, pointer=1, state=AUTO, grant=00, sel_code=000, tick=0, done=0.
REQ-026 Reset asserted during HOLD SHALL abandon the grant without a done pulse.
REQ-027 After rst deasserts, the first tick SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV=4, HOLD_TICKS=2)
REQ-028 No requests, 40 cycles after reset -> tick every 4th cycle; sel_code steps 0,1,...,7,0,1,2.
REQ-029 req=11 held from the same edge -> grant=01 next cycle, sel_code=code0; released after 2 ticks with done=1; grant=10 one AUTO cycle later.
REQ-030 req=01 asserted, then dropped 3 cycles into HOLD -> grant=00 and done=1 at the next edge, sel_code back to the frozen auto value.
REQ-031 code0 changes 5->2 during HOLD of requester 0 -> sel_code stays 5.
REQ-032 rst=1 during HOLD -> next cycle grant=00, sel_code=000, done=0; after release, first tick 4 cycles later.
